fp_add_ctrl: RTL and testbench
==============================

FP_ADD_CTRL -- requirements
Module: fp_add_ctrl

Interface
REQ-001 SHALL have parameter ALIGN_STEP, default 1: mantissa right-shift bits per ALIGN cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk_i, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port start_i, input, 1: request; accepted only in a cycle where ready_o=1.
REQ-005 SHALL have port sub_i, input, 1: 1 = compute x-y (y sign inverted at capture).
REQ-006 SHALL have ports x_i and y_i, input, 32 each: IEEE-754 single operands, sampled on accept.
REQ-007 SHALL have port ready_o, output, 1: high only in IDLE.
REQ-008 SHALL have port valid_o, output, 1: result_o valid; high only in DONE.
REQ-009 SHALL have port ack_i, input, 1: consumer accepts result.
REQ-010 SHALL have port result_o, output, 32: sum, held stable while valid_o=1.
REQ-011 SHALL have ports infinity_o and nan_o, output, 1 each: status of result_o, valid with valid_o.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, DONE.
REQ-013 On accept, registers SHALL capture sign, exponent and 24-bit mantissa of each operand (hidden bit 1 if exp!=0); exp==0 operands SHALL be treated as zero (flush).
REQ-014 If either operand is NaN, or the operands are infinities of opposite effective sign, IDLE SHALL go directly to DONE with result 0x7FC00000 and nan_o=1.
REQ-015 Otherwise, if either operand is infinite, IDLE SHALL go directly to DONE with that signed infinity and infinity_o=1.
REQ-016 ALIGN SHALL shift the smaller-exponent mantissa right by ALIGN_STEP per cycle, taking the larger exponent, for max(1, ceil(shift/ALIGN_STEP)) cycles; shift>=26 SHALL zero that mantissa in one cycle; bits shifted out SHALL be discarded (truncation).
REQ-017 ADD SHALL take 1 cycle: same effective signs add magnitudes; different signs subtract the smaller magnitude from the larger; result sign = sign of the larger magnitude; exact cancellation gives +0.
REQ-018 NORM SHALL take at least 1 cycle: on carry, shift right 1 and increment exponent once; else shift left 1 and decrement exponent per cycle until bit 23 set.
REQ-019 In NORM, exponent reaching 255 SHALL produce signed infinity with infinity_o=1; exponent reaching 0 or a zero mantissa SHALL produce +0x00000000.
REQ-020 Latency SHALL be: accept in cycle N; with equal exponents and no left shift, valid_o=1 in cycle N+4; special cases valid_o=1 in cycle N+1.
REQ-021 valid_o SHALL stay high until ack_i=1; ack_i in DONE SHALL return the FSM to IDLE next cycle; ack_i outside DONE SHALL be ignored.
REQ-022 start_i while ready_o=0 SHALL be ignored, with no queuing.

Reset
REQ-023 rst_ni=0 at a clock edge SHALL force IDLE from any state, abandoning any operation in flight.
REQ-024 During and after reset: ready_o=1, valid_o=0, result_o=0, infinity_o=0, nan_o=0, all internal datapath registers 0.

Configuration
REQ-025 With macro FP_ADD_CTRL_ABORT_EN defined, the module SHALL have input abort_i (1 bit).
REQ-026 With FP_ADD_CTRL_ABORT_EN defined, abort_i=1 in ALIGN, ADD or NORM SHALL return the FSM to IDLE next cycle with valid_o never asserted for that operation; abort_i SHALL be ignored in IDLE and DONE.
REQ-027 Without FP_ADD_CTRL_ABORT_EN, abort_i SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-028 x=0x3F800000, y=0x3F800000, sub_i=0, accepted cycle N -> valid_o at N+4, result 0x40000000, flags 0.
REQ-029 x=0x40400000, y=0x3F800000, sub_i=1 -> result 0x40000000; x=0x3F800000, y=0xBF800000 -> result 0x00000000.
REQ-030 x=0x3FC00000, y=0x30800000 (shift 30) -> one ALIGN cycle, result 0x3FC00000.
REQ-031 x=0x7F800000, y=0xFF800000 -> valid_o at N+1, result 0x7FC00000, nan_o=1; x=0x7F7FFFFF, y=0x7F7FFFFF -> 0x7F800000, infinity_o=1.
REQ-032 Hold ack_i=0 for 5 cycles in DONE -> result_o stable and start_i ignored; then assert rst_ni=0 mid-ALIGN -> next cycle ready_o=1, valid_o=0.
REQ-033 With FP_ADD_CTRL_ABORT_EN defined, abort_i=1 in ADD -> IDLE next cycle, no valid_o pulse, and the next request completes normally.

Source files
------------

// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: multi-cycle IEEE-754 single add/sub controller (IDLE/ALIGN/ADD/NORM/DONE).
// Optional abort_i input enabled by macro FP_ADD_CTRL_ABORT_EN.
module fp_add_ctrl #(
    parameter int ALIGN_STEP = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        sub_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic        ack_i,
`ifdef FP_ADD_CTRL_ABORT_EN
    input  logic        abort_i,
`endif
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        infinity_o,
    output logic        nan_o
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    localparam logic [7:0] STEP = 8'(ALIGN_STEP);

    state_t      r_state;
    logic        r_ready, r_valid, r_inf, r_nan;
    logic [31:0] r_result;
    logic        r_sx, r_sy, r_s;
    logic [7:0]  r_ex, r_ey, r_e;
    logic [23:0] r_mx, r_my;
    logic [24:0] r_m;

    logic        w_abort;
`ifdef FP_ADD_CTRL_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    logic [7:0]  w_xe, w_ye, w_d, w_st, w_ne;
    logic        w_ys, w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_nan, w_inf, w_inf_s;
    logic        w_x_big, w_same, w_xge;
    logic [24:0] w_sum, w_nm;

    assign w_xe    = x_i[30:23];
    assign w_ye    = y_i[30:23];
    assign w_ys    = y_i[31] ^ sub_i;
    assign w_x_nan = (&w_xe) && (|x_i[22:0]);
    assign w_y_nan = (&w_ye) && (|y_i[22:0]);
    assign w_x_inf = (&w_xe) && !(|x_i[22:0]);
    assign w_y_inf = (&w_ye) && !(|y_i[22:0]);
    assign w_nan   = w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (x_i[31] != w_ys));
    assign w_inf   = w_x_inf || w_y_inf;
    assign w_inf_s = w_x_inf ? x_i[31] : w_ys;

    assign w_x_big = r_ex >= r_ey;
    assign w_d     = w_x_big ? r_ex - r_ey : r_ey - r_ex;
    assign w_st    = (w_d > STEP) ? STEP : w_d;

    assign w_same  = r_sx == r_sy;
    assign w_xge   = r_mx >= r_my;
    assign w_sum   = w_same ? {1'b0, r_mx} + {1'b0, r_my} :
                     w_xge  ? {1'b0, r_mx} - {1'b0, r_my} : {1'b0, r_my} - {1'b0, r_mx};

    // one normalisation step: carry shifts right, otherwise shift left until bit 23 is set
    assign w_nm    = r_m[24] ? r_m >> 1 : r_m[23] ? r_m : r_m << 1;
    assign w_ne    = r_m[24] ? r_e + 8'd1 : r_m[23] ? r_e : r_e - 8'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_inf    <= 1'b0;
            r_nan    <= 1'b0;
            r_result <= '0;
            r_sx     <= 1'b0;
            r_sy     <= 1'b0;
            r_s      <= 1'b0;
            r_ex     <= '0;
            r_ey     <= '0;
            r_e      <= '0;
            r_mx     <= '0;
            r_my     <= '0;
            r_m      <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_ready <= 1'b0;
                    r_sx    <= x_i[31];
                    r_sy    <= w_ys;
                    r_ex    <= w_xe;
                    r_ey    <= w_ye;
                    r_mx    <= (w_xe != 8'd0) ? {1'b1, x_i[22:0]} : 24'd0;
                    r_my    <= (w_ye != 8'd0) ? {1'b1, y_i[22:0]} : 24'd0;
                    r_nan   <= w_nan;
                    r_inf   <= !w_nan && w_inf;
                    if (w_nan || w_inf) begin
                        r_result <= w_nan ? 32'h7FC00000 : {w_inf_s, 8'hFF, 23'd0};
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_state  <= ALIGN;
                    end
                end
                ALIGN: if (w_abort) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end else if (w_d >= 8'd26) begin
                    if (w_x_big) begin
                        r_my <= '0;
                        r_ey <= r_ex;
                    end else begin
                        r_mx <= '0;
                        r_ex <= r_ey;
                    end
                    r_state <= ADD;
                end else begin
                    if (w_x_big) begin
                        r_my <= r_my >> w_st;
                        r_ey <= r_ey + w_st;
                    end else begin
                        r_mx <= r_mx >> w_st;
                        r_ex <= r_ex + w_st;
                    end
                    if (w_d <= STEP) r_state <= ADD;
                end
                ADD: if (w_abort) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end else begin
                    r_m     <= w_sum;
                    r_s     <= (w_same || w_xge) ? r_sx : r_sy;
                    r_e     <= r_ex;
                    r_state <= NORM;
                end
                NORM: if (w_abort) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end else if (r_m == 25'd0 || (w_ne == 8'd0 && w_ne != 8'hFF)) begin
                    r_result <= '0;
                    r_inf    <= 1'b0;
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end else if (w_ne == 8'hFF) begin
                    r_result <= {r_s, 8'hFF, 23'd0};
                    r_inf    <= 1'b1;
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end else if (w_nm[23]) begin
                    r_result <= {r_s, w_ne, w_nm[22:0]};
                    r_valid  <= 1'b1;
                    r_state  <= DONE;
                end else begin
                    r_m <= w_nm;
                    r_e <= w_ne;
                end
                DONE: if (ack_i) begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign valid_o    = r_valid;
    assign result_o   = r_result;
    assign infinity_o = r_inf;
    assign nan_o      = r_nan;
endmodule

// File: tb/tb_fp_add_ctrl.sv
// tb_fp_add_ctrl: directed-vector bench for fp_add_ctrl (ALIGN_STEP=1).
// Abort scenario is exercised only when FP_ADD_CTRL_ABORT_EN is defined.
module tb_fp_add_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        sub_i = 1'b0;
    logic [31:0] x_i = '0;
    logic [31:0] y_i = '0;
    logic        ack_i = 1'b0;
    logic        ready_o, valid_o, infinity_o, nan_o;
    logic [31:0] result_o;
`ifdef FP_ADD_CTRL_ABORT_EN
    logic        abort_i = 1'b0;
`endif
    int checks = 0;
    int failures = 0;

    fp_add_ctrl #(.ALIGN_STEP(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .sub_i(sub_i),
        .x_i(x_i), .y_i(y_i), .ack_i(ack_i),
`ifdef FP_ADD_CTRL_ABORT_EN
        .abort_i(abort_i),
`endif
        .ready_o(ready_o), .valid_o(valid_o), .result_o(result_o),
        .infinity_o(infinity_o), .nan_o(nan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // accept one request, wait for valid_o, return cycles from accept edge
    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic sub, output int n);
        x_i = x; y_i = y; sub_i = sub; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic sub,
                      input logic [31:0] er, input logic ei, input logic en, input int lat);
        int n;
        launch(x, y, sub, n);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        if (lat > 0) chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, result_o, er);
        chk({tag, "_inf"}, {31'd0, infinity_o}, {31'd0, ei});
        chk({tag, "_nan"}, {31'd0, nan_o}, {31'd0, en});
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk({tag, "_ready"}, {30'd0, ready_o, valid_o}, 32'd2);
    endtask

    initial begin
        int n;
        repeat (2) tick();
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_flags", {30'd0, infinity_o, nan_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);
        op("three_m_one",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 4);
        op("cancel",       32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0, 4);
        op("shift30",      32'h3FC00000, 32'h30800000, 1'b0, 32'h3FC00000, 1'b0, 1'b0, 4);
        op("inf_nan",      32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 1);
        op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 0);
        op("shift3",       32'h41000000, 32'h3F800000, 1'b0, 32'h41100000, 1'b0, 1'b0, 6);
        op("neg_result",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 0);
        op("left23",       32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0, 0);
        op("inf_fin",      32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1);
        op("qnan_in",      32'h3F800000, 32'h7FC00000, 1'b0, 32'h7FC00000, 1'b0, 1'b1, 1);
        op("inf_sub_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1, 1);
        op("denorm_flush", 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 0);
        op("underflow",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 0);

        // hold in DONE with start_i pulsing: result must not move
        launch(32'h3F800000, 32'h3F800000, 1'b0, n);
        chk("hold_valid0", {31'd0, valid_o}, 32'd1);
        x_i = 32'h40400000; y_i = 32'h40400000; start_i = 1'b1;
        repeat (5) tick();
        start_i = 1'b0;
        chk("hold_result", result_o, 32'h40000000);
        chk("hold_state", {30'd0, ready_o, valid_o}, 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("hold_release", {30'd0, ready_o, valid_o}, 32'd2);
        tick();
        chk("no_queue", {30'd0, ready_o, valid_o}, 32'd2);

        // reset in the middle of a 3-cycle ALIGN
        x_i = 32'h41000000; y_i = 32'h3F800000; sub_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("midrst_state", {30'd0, ready_o, valid_o}, 32'd2);
        chk("midrst_result", result_o, 32'd0);
        op("after_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 4);

`ifdef FP_ADD_CTRL_ABORT_EN
        x_i = 32'h3F800000; y_i = 32'h3F800000; sub_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_state", {30'd0, ready_o, valid_o}, 32'd2);
        repeat (4) begin
            tick();
            chk("abort_novalid", {31'd0, valid_o}, 32'd0);
        end
        op("after_abort", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
